// File: rtl/mem_responder.sv
// Memory-side responder: owns instruction ROM and data RAM, streams a program into ROM, then releases the CPU.
// Optional feature: define MEM_RESPONDER_RELOAD_EN to add the `reload` input (RUN -> LOAD re-entry).
module mem_responder #(
    parameter int unsigned ROM_AW = 8,
    parameter int unsigned RAM_AW = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] address_rom,
    output logic [15:0] data_rom,
    input  logic [15:0] address_ram,
    input  logic [15:0] wdata_ram,
    input  logic        we_ram,
    output logic [15:0] data_ram,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
`ifdef MEM_RESPONDER_RELOAD_EN
    input  logic        reload,
`endif
    output logic        load_overflow,
    output logic        cpu_run
);

    localparam int unsigned DW        = 16;
    localparam int unsigned ROM_DEPTH = 1 << ROM_AW;
    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ROM_AW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]       data_rom_q, data_rom_d;
    logic [DW-1:0]       data_ram_q, data_ram_d;
    logic                overflow_q, overflow_d;
    logic                cpu_run_q, cpu_run_d;
    logic                load_ready_q, load_ready_d;
    logic                rom_we, ram_we;
    logic                rom_oor, ram_oor, ptr_full, reload_req;

    logic [DW-1:0]       rom_mem [ROM_DEPTH];
    logic [DW-1:0]       ram_mem [RAM_DEPTH];

`ifdef MEM_RESPONDER_RELOAD_EN
    assign reload_req = reload;
`else
    assign reload_req = 1'b0;
`endif

    assign rom_oor  = |address_rom[15:ROM_AW];
    assign ram_oor  = |address_ram[15:RAM_AW];
    assign ptr_full = (ptr_q == {ROM_AW{1'b1}});

    // State, pointer and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_LOAD;
            ptr_q        <= '0;
            data_rom_q   <= '0;
            data_ram_q   <= '0;
            overflow_q   <= 1'b0;
            cpu_run_q    <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            data_rom_q   <= data_rom_d;
            data_ram_q   <= data_ram_d;
            overflow_q   <= overflow_d;
            cpu_run_q    <= cpu_run_d;
            load_ready_q <= load_ready_d;
        end
    end

    // Next-state, memory write enables and read data
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        overflow_d   = overflow_q;
        cpu_run_d    = cpu_run_q;
        load_ready_d = load_ready_q;
        data_rom_d   = '0;
        data_ram_d   = '0;
        rom_we       = 1'b0;
        ram_we       = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (load_valid && load_ready_q) begin
                    rom_we = 1'b1;
                    ptr_d  = ptr_q + ROM_AW'(1);
                    if (load_last || ptr_full) begin
                        state_d      = ST_RUN;
                        cpu_run_d    = 1'b1;
                        load_ready_d = 1'b0;
                        if (!load_last) begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (reload_req) begin
                    state_d      = ST_LOAD;
                    ptr_d        = '0;
                    overflow_d   = 1'b0;
                    cpu_run_d    = 1'b0;
                    load_ready_d = 1'b1;
                end else begin
                    ram_we     = we_ram && !ram_oor;
                    data_rom_d = rom_oor ? '0 : rom_mem[address_rom[ROM_AW-1:0]];
                    // Single address port, so a write always targets the read address: forward it
                    if (ram_oor) begin
                        data_ram_d = '0;
                    end else if (we_ram) begin
                        data_ram_d = wdata_ram;
                    end else begin
                        data_ram_d = ram_mem[address_ram[RAM_AW-1:0]];
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Memory arrays carry no reset
    always_ff @(posedge clock) begin
        if (rom_we) begin
            rom_mem[ptr_q] <= load_data;
        end
        if (ram_we) begin
            ram_mem[address_ram[RAM_AW-1:0]] <= wdata_ram;
        end
    end

    assign data_rom      = data_rom_q;
    assign data_ram      = data_ram_q;
    assign load_ready    = load_ready_q;
    assign load_overflow = overflow_q;
    assign cpu_run       = cpu_run_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: default-size instance plus a ROM_AW=2 instance for overflow.
module tb_mem_responder;

    logic        clock;
    logic        reset_n;
    logic [15:0] address_rom, address_ram, wdata_ram, load_data;
    logic        we_ram, load_valid, load_last, reload;
    logic [15:0] data_rom, data_ram;
    logic        load_ready, load_overflow, cpu_run;

    logic [15:0] s_address_rom, s_load_data;
    logic        s_load_valid, s_load_last;
    logic [15:0] s_data_rom, s_data_ram;
    logic        s_load_ready, s_load_overflow, s_cpu_run;
    logic [15:0] s_address_ram, s_wdata_ram;
    logic        s_we_ram;

    int n_tests;
    int n_fail;
    logic [15:0] exp_q [$];

    mem_responder #(.ROM_AW(8), .RAM_AW(8)) u_dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address_rom   (address_rom),
        .data_rom      (data_rom),
        .address_ram   (address_ram),
        .wdata_ram     (wdata_ram),
        .we_ram        (we_ram),
        .data_ram      (data_ram),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
`ifdef MEM_RESPONDER_RELOAD_EN
        .reload        (reload),
`endif
        .load_overflow (load_overflow),
        .cpu_run       (cpu_run)
    );

    mem_responder #(.ROM_AW(2), .RAM_AW(8)) u_small (
        .clock         (clock),
        .reset_n       (reset_n),
        .address_rom   (s_address_rom),
        .data_rom      (s_data_rom),
        .address_ram   (s_address_ram),
        .wdata_ram     (s_wdata_ram),
        .we_ram        (s_we_ram),
        .data_ram      (s_data_ram),
        .load_valid    (s_load_valid),
        .load_data     (s_load_data),
        .load_last     (s_load_last),
        .load_ready    (s_load_ready),
`ifdef MEM_RESPONDER_RELOAD_EN
        .reload        (1'b0),
`endif
        .load_overflow (s_load_overflow),
        .cpu_run       (s_cpu_run)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if (cpu_run !== 1'b0 || data_rom !== 16'h0 || data_ram !== 16'h0 || load_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: run=%b rom=%h ram=%h ovf=%b required 0/0000/0000/0", cpu_run, data_rom, data_ram, load_overflow);
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        n_tests++;
        if (load_ready !== 1'b1 || cpu_run !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b run=%b required 1/0", load_ready, cpu_run);
        end
    endtask

    task automatic test_basic_load();
        logic [15:0] words [3] = '{16'h0001, 16'h0005, 16'h0006};
        address_rom = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = (i == 2);
            tick();
            if (i < 2) begin
                n_tests++;
                if (cpu_run !== 1'b0 || load_ready !== 1'b1 || data_rom !== 16'h0) begin
                    n_fail++;
                    $display("FAIL load_word%0d: run=%b ready=%b rom=%h required 0/1/0000", i, cpu_run, load_ready, data_rom);
                end
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        n_tests++;
        if (cpu_run !== 1'b1 || load_ready !== 1'b0 || load_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: run=%b ready=%b ovf=%b required 1/0/0", cpu_run, load_ready, load_overflow);
        end
        for (int i = 0; i < 3; i++) begin
            address_rom = 16'(i);
            exp_q.push_back(words[i]);
            tick();
            n_tests++;
            if (data_rom !== exp_q[0]) begin
                n_fail++;
                $display("FAIL fetch_%0d: got %h required %h", i, data_rom, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_out_of_range();
        address_rom = 16'h0100;
        exp_q.push_back(16'h0000);
        tick();
        n_tests++;
        if (data_rom !== exp_q[0]) begin
            n_fail++;
            $display("FAIL fetch_oor: got %h required %h", data_rom, exp_q[0]);
        end
        void'(exp_q.pop_front());
        address_ram = 16'h0000; wdata_ram = 16'h1111; we_ram = 1'b1;
        tick();
        address_ram = 16'h0100; wdata_ram = 16'hDEAD; we_ram = 1'b1;
        exp_q.push_back(16'h0000);
        tick();
        n_tests++;
        if (data_ram !== exp_q[0]) begin
            n_fail++;
            $display("FAIL ram_oor_write: got %h required %h", data_ram, exp_q[0]);
        end
        void'(exp_q.pop_front());
        address_ram = 16'h0000; we_ram = 1'b0;
        exp_q.push_back(16'h1111);
        tick();
        n_tests++;
        if (data_ram !== exp_q[0]) begin
            n_fail++;
            $display("FAIL ram_oor_nowrite: got %h required %h", data_ram, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_ram();
        logic [15:0] addr [4] = '{16'h0010, 16'h0010, 16'h0020, 16'h0010};
        logic [15:0] wd   [4] = '{16'hBEEF, 16'h0000, 16'h1234, 16'h0000};
        logic        we   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] expv [4] = '{16'hBEEF, 16'hBEEF, 16'h1234, 16'hBEEF};
        for (int i = 0; i < 4; i++) begin
            address_ram = addr[i]; wdata_ram = wd[i]; we_ram = we[i];
            exp_q.push_back(expv[i]);
            tick();
            n_tests++;
            if (data_ram !== exp_q[0]) begin
                n_fail++;
                $display("FAIL ram_%0d: got %h required %h", i, data_ram, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        we_ram = 1'b0;
    endtask

    task automatic test_overflow();
        logic [15:0] words [4] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
        for (int i = 0; i < 4; i++) begin
            s_load_valid = 1'b1; s_load_data = words[i]; s_load_last = 1'b0;
            tick();
        end
        n_tests++;
        if (s_cpu_run !== 1'b1 || s_load_overflow !== 1'b1 || s_load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_flag: run=%b ovf=%b ready=%b required 1/1/0", s_cpu_run, s_load_overflow, s_load_ready);
        end
        s_load_data = 16'hFFFF;
        tick();
        s_load_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_address_rom = 16'(i);
            exp_q.push_back(i < 4 ? words[i] : 16'h0000);
            tick();
            n_tests++;
            if (s_data_rom !== exp_q[0]) begin
                n_fail++;
                $display("FAIL overflow_fetch_%0d: got %h required %h", i, s_data_rom, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset_mid_load();
        address_rom = 16'h0000; address_ram = 16'h0010; we_ram = 1'b0;
        tick();
        n_tests++;
        if (data_rom !== 16'h0001 || data_ram !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL pre_reset: rom=%h ram=%h required 0001/beef", data_rom, data_ram);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (cpu_run !== 1'b0 || data_rom !== 16'h0 || data_ram !== 16'h0 || s_load_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: run=%b rom=%h ram=%h sovf=%b required 0/0000/0000/0", cpu_run, data_rom, data_ram, s_load_overflow);
        end
        tick();
        reset_n = 1'b1;
        load_valid = 1'b1; load_last = 1'b0;
        load_data = 16'h0A0A; tick();
        load_data = 16'h0B0B; tick();
        load_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (cpu_run !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midload_reset: run=%b ready=%b required 0/1", cpu_run, load_ready);
        end
        tick();
        reset_n = 1'b1;
        load_valid = 1'b1; load_last = 1'b1; load_data = 16'h00C3;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        n_tests++;
        if (cpu_run !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_one_word: run=%b required 1", cpu_run);
        end
        for (int i = 0; i < 2; i++) begin
            address_rom = 16'(i);
            exp_q.push_back(i == 0 ? 16'h00C3 : 16'h0B0B);
            tick();
            n_tests++;
            if (data_rom !== exp_q[0]) begin
                n_fail++;
                $display("FAIL after_reset_fetch_%0d: got %h required %h", i, data_rom, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

`ifdef MEM_RESPONDER_RELOAD_EN
    task automatic test_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        n_tests++;
        if (cpu_run !== 1'b0 || load_ready !== 1'b1 || load_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_state: run=%b ready=%b ovf=%b required 0/1/0", cpu_run, load_ready, load_overflow);
        end
        load_valid = 1'b1; load_last = 1'b1; load_data = 16'h000B;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        address_rom = 16'h0000;
        exp_q.push_back(16'h000B);
        tick();
        n_tests++;
        if (cpu_run !== 1'b1 || data_rom !== exp_q[0]) begin
            n_fail++;
            $display("FAIL reload_fetch: run=%b got %h required 1/%h", cpu_run, data_rom, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask
`endif

    initial begin
        n_tests = 0; n_fail = 0;
        reset_n = 1'b0; reload = 1'b0;
        address_rom = '0; address_ram = '0; wdata_ram = '0; we_ram = 1'b0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        s_address_rom = '0; s_address_ram = '0; s_wdata_ram = '0; s_we_ram = 1'b0;
        s_load_valid = 1'b0; s_load_data = '0; s_load_last = 1'b0;
        test_reset();
        test_basic_load();
        test_out_of_range();
        test_ram();
        test_overflow();
        test_reset_mid_load();
`ifdef MEM_RESPONDER_RELOAD_EN
        test_reload();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
